dmac_cfg: RTL and testbench
===========================

DMAC_CFG -- requirements
Module: dmac_cfg

Interface
- REQ-001 The block SHALL have parameter N_CH, default 4, meaning the number of DMA channels (1..15).
- REQ-002 The block SHALL have parameter IP_VERSION, default 32'h0002_0101, meaning the value returned at offset 0x000.
- REQ-003 The block SHALL have one clock and an asynchronous active-low reset, with ports as listed in REQ-004 to REQ-017.
- REQ-004 Port: clk  in  1  rising-edge clock.
- REQ-005 Port: rst_n  in  1  asynchronous active-low reset.
- REQ-006 Port: psel_i  in  1  APB select.
- REQ-007 Port: penable_i  in  1  APB enable (access phase).
- REQ-008 Port: paddr_i  in  12  APB byte address.
- REQ-009 Port: pwrite_i  in  1  1 = write, 0 = read.
- REQ-010 Port: pwdata_i  in  32  APB write data.
- REQ-011 Port: pready_o  out  1  APB ready.
- REQ-012 Port: prdata_o  out  32  APB read data.
- REQ-013 Port: pslverr_o  out  1  APB error.
- REQ-014 Port: ch_src_o  out  N_CH x 32  per-channel source address to the channel engine.
- REQ-015 Port: ch_dst_o  out  N_CH x 32  per-channel destination address.
- REQ-016 Port: ch_len_o  out  N_CH x 16  per-channel byte length.
- REQ-017 Ports: ch_start_o  out  N_CH  one-cycle start pulse per channel; ch_done_i  in  N_CH  one-cycle completion pulse from each engine.

Function
- REQ-018 Address map: 0x000 = IP_VERSION (read-only). Channel n (0..N_CH-1) base = (n+1)*0x100, with offsets +0x0 SRC, +0x4 DST, +0x8 LEN, +0xC CMD (write-only), +0x10 STAT (read-only).
- REQ-019 The block SHALL insert zero wait states: pready_o = psel_i & penable_i.
- REQ-020 Writes SHALL take effect on the clock edge that ends the access phase (psel_i & penable_i & pwrite_i). Writes to read-only or unmapped offsets are ignored.
- REQ-021 prdata_o SHALL be registered on the setup-phase edge (psel_i & !penable_i & !pwrite_i) and held through the access phase.
- REQ-022 Read values: SRC/DST full 32 bits; LEN = {16'h0, len}; STAT = {31'h0, idle}; CMD and unmapped offsets read 0.
- REQ-023 A LEN write SHALL store pwdata_i[15:0]; bits [31:16] are discarded.
- REQ-024 Per-channel state: IDLE (idle=1) and BUSY (idle=0).
- REQ-025 A CMD write with pwdata_i[0]=1 in IDLE SHALL pulse ch_start_o[n] high for exactly the next cycle and enter BUSY.
- REQ-026 A CMD write in BUSY, or with pwdata_i[0]=0, SHALL be ignored.
- REQ-027 ch_done_i[n] in BUSY SHALL return the channel to IDLE; ch_done_i in IDLE is ignored.
- REQ-028 When a done pulse and a CMD write hit the same channel in the same cycle, the CMD write SHALL be evaluated against the pre-edge state (BUSY, so ignored); the done pulse still returns the channel to IDLE.
- REQ-029 SRC, DST and LEN SHALL remain writable in BUSY. Engines sample them only on ch_start_o, so an in-flight transfer is unaffected.
- REQ-030 Channels SHALL operate independently; accesses to one channel never alter another channel's state.

Reset
- REQ-031 While rst_n=0: SRC, DST and LEN = 0; every channel IDLE; ch_start_o = 0; prdata_o = 0; pslverr_o = 0.
- REQ-032 Reset asserted mid-transfer SHALL return the channel to IDLE immediately with no start pulse; the engine is reset by the same rst_n.

Configuration
- REQ-033 With DMAC_CFG_SLVERR_EN defined, pslverr_o SHALL equal psel_i & penable_i & (unmapped offset OR channel index >= N_CH OR CMD write in BUSY OR write to read-only).
- REQ-034 Without DMAC_CFG_SLVERR_EN, pslverr_o SHALL be constant 0 and such accesses are silently ignored.

Structure
- REQ-035 Package dmac_cfg_pkg SHALL hold the offset constants (SRC/DST/LEN/CMD/STAT), CH_SFR_SIZE = 0x100, the default IP_VERSION, and a typedef for the channel state.
- REQ-036 Sub-module dmac_cfg_ch SHALL implement one channel's registers, FSM and start pulse, and SHALL be instantiated N_CH times. The top level decodes addresses and muxes read data.

Verification
- REQ-037 After reset, read 0x000 -> 32'h0002_0101; read 0x110 -> 1; read 0x100 -> 0.
- REQ-038 Write 0x200 = 32'h0000_1000, then read 0x200 -> 32'h0000_1000. Write 0x208 = 32'h0001_0100, then read 0x208 -> 32'h0000_0100 and ch_len_o[1] = 16'h0100.
- REQ-039 Write 0x30C = 1 -> ch_start_o[2] high exactly one cycle, read 0x310 -> 0. A second 0x30C write -> no pulse (pslverr_o=1 with the macro defined). Pulse ch_done_i[2] -> read 0x310 -> 1.
- REQ-040 Drive ch_done_i[0] and a 0x10C write in the same cycle while channel 0 is BUSY -> no start pulse and STAT reads 1.
- REQ-041 Access 0x500 with N_CH=4 -> read 0, no state change, pslverr_o=1 only when DMAC_CFG_SLVERR_EN is defined.
- REQ-042 Start all four channels back-to-back, then assert rst_n=0 mid-transfer -> all STAT read 1 after release and no ch_start_o pulses occur.

Source files
------------

// File: rtl/dmac_cfg_pkg.sv
// DMA controller configuration block: shared constants and types.
// Offsets are relative to a channel's 0x100-byte register page.
package dmac_cfg_pkg;

    localparam logic [7:0]  OFF_SRC  = 8'h00;
    localparam logic [7:0]  OFF_DST  = 8'h04;
    localparam logic [7:0]  OFF_LEN  = 8'h08;
    localparam logic [7:0]  OFF_CMD  = 8'h0C;
    localparam logic [7:0]  OFF_STAT = 8'h10;

    localparam int unsigned CH_SFR_SIZE    = 32'h100;
    localparam int unsigned PAGE_LSB       = $clog2(CH_SFR_SIZE);
    localparam logic [31:0] IP_VERSION_DEF = 32'h0002_0101;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_BUSY = 1'b1
    } ch_state_e;

    function automatic logic off_mapped(input logic [7:0] off);
        return off inside {OFF_SRC, OFF_DST, OFF_LEN, OFF_CMD, OFF_STAT};
    endfunction

endpackage

// File: rtl/dmac_cfg_ch.sv
// One DMA channel: SRC/DST/LEN registers, IDLE/BUSY FSM, start pulse.
// Address decode of the page is done by the parent; this sees offsets.
module dmac_cfg_ch
    import dmac_cfg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en_i,
    input  logic [7:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic        done_i,
    output logic [31:0] src_o,
    output logic [31:0] dst_o,
    output logic [15:0] len_o,
    output logic        start_o,
    output logic        idle_o
);

    logic [31:0] src_q;
    logic [31:0] dst_q;
    logic [15:0] len_q;
    ch_state_e   state_q, state_d;
    logic        start_q, start_d;
    logic        cmd_go;

    assign cmd_go = wr_en_i && (off_i == OFF_CMD) && wdata_i[0];

    // Address registers stay writable while BUSY; engines latch on start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q <= '0;
            dst_q <= '0;
            len_q <= '0;
        end else if (wr_en_i) begin
            case (off_i)
                OFF_SRC: src_q <= wdata_i;
                OFF_DST: dst_q <= wdata_i;
                OFF_LEN: len_q <= wdata_i[15:0];
                default: ;
            endcase
        end
    end

    // Next state: CMD only counts in IDLE, done only counts in BUSY.
    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        unique case (state_q)
            CH_IDLE: begin
                if (cmd_go) begin
                    state_d = CH_BUSY;
                    start_d = 1'b1;
                end
            end
            CH_BUSY: begin
                if (done_i) begin
                    state_d = CH_IDLE;
                end
            end
            default: state_d = CH_IDLE;
        endcase
    end

    // State register and the registered one-cycle start pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CH_IDLE;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
        end
    end

    assign src_o   = src_q;
    assign dst_o   = dst_q;
    assign len_o   = len_q;
    assign start_o = start_q;
    assign idle_o  = (state_q == CH_IDLE);

endmodule

// File: rtl/dmac_cfg.sv
// APB configuration front-end for an N_CH-channel DMA controller.
// Optional DMAC_CFG_SLVERR_EN flags bad accesses on pslverr_o.
module dmac_cfg
    import dmac_cfg_pkg::*;
#(
    parameter int          N_CH       = 4,
    parameter logic [31:0] IP_VERSION = IP_VERSION_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      psel_i,
    input  logic                      penable_i,
    input  logic [11:0]               paddr_i,
    input  logic                      pwrite_i,
    input  logic [31:0]               pwdata_i,
    output logic                      pready_o,
    output logic [31:0]               prdata_o,
    output logic                      pslverr_o,
    output logic [N_CH-1:0][31:0]     ch_src_o,
    output logic [N_CH-1:0][31:0]     ch_dst_o,
    output logic [N_CH-1:0][15:0]     ch_len_o,
    output logic [N_CH-1:0]           ch_start_o,
    input  logic [N_CH-1:0]           ch_done_i
);

    logic [3:0]      page;
    logic [7:0]      off;
    logic            acc;
    logic            wr_acc;
    logic            setup_rd;
    logic            ch_ok;
    logic [N_CH-1:0] wr_en;
    logic [N_CH-1:0] idle;
    logic [31:0]     rdata_d;
    logic [31:0]     prdata_q;

    // Page 0 holds global registers; page n+1 is channel n.
    assign page     = paddr_i[11:PAGE_LSB];
    assign off      = paddr_i[PAGE_LSB-1:0];
    assign acc      = psel_i & penable_i;
    assign wr_acc   = acc & pwrite_i;
    assign setup_rd = psel_i & ~penable_i & ~pwrite_i;
    assign ch_ok    = (page != 4'd0) && (page <= 4'(N_CH));
    assign pready_o = acc;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign wr_en[g] = wr_acc && (page == 4'(g + 1));

        dmac_cfg_ch u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en_i (wr_en[g]),
            .off_i   (off),
            .wdata_i (pwdata_i),
            .done_i  (ch_done_i[g]),
            .src_o   (ch_src_o[g]),
            .dst_o   (ch_dst_o[g]),
            .len_o   (ch_len_o[g]),
            .start_o (ch_start_o[g]),
            .idle_o  (idle[g])
        );
    end

    // Read mux; CMD, unmapped and out-of-range pages read as zero.
    always_comb begin
        rdata_d = '0;
        if (page == 4'd0 && off == 8'h00) begin
            rdata_d = IP_VERSION;
        end
        for (int n = 0; n < N_CH; n++) begin
            if (page == 4'(n + 1)) begin
                case (off)
                    OFF_SRC:  rdata_d = ch_src_o[n];
                    OFF_DST:  rdata_d = ch_dst_o[n];
                    OFF_LEN:  rdata_d = {16'h0, ch_len_o[n]};
                    OFF_STAT: rdata_d = {31'h0, idle[n]};
                    default:  rdata_d = '0;
                endcase
            end
        end
    end

    // Read data is captured in the setup phase and held afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prdata_q <= '0;
        end else if (setup_rd) begin
            prdata_q <= rdata_d;
        end
    end

    assign prdata_o = prdata_q;

`ifdef DMAC_CFG_SLVERR_EN
    logic sel_busy;
    logic unmapped;
    logic oob;
    logic ro_wr;
    logic busy_cmd;

    // Busy flag of the addressed channel, for the CMD-in-BUSY error.
    always_comb begin
        sel_busy = 1'b0;
        for (int n = 0; n < N_CH; n++) begin
            if (page == 4'(n + 1)) begin
                sel_busy = ~idle[n];
            end
        end
    end

    assign unmapped = (page == 4'd0) ? (off != 8'h00)
                    : (ch_ok & ~off_mapped(off));
    assign oob      = (page > 4'(N_CH));
    assign ro_wr    = pwrite_i & (((page == 4'd0) & (off == 8'h00))
                    | (ch_ok & (off == OFF_STAT)));
    assign busy_cmd = pwrite_i & ch_ok & (off == OFF_CMD) & sel_busy;

    assign pslverr_o = rst_n & acc & (unmapped | oob | ro_wr | busy_cmd);
`else
    assign pslverr_o = 1'b0;
`endif

endmodule

// File: tb/tb_dmac_cfg.sv
// Bench for dmac_cfg: directed checks plus randomized APB traffic
// compared each cycle against a register-map model.
`timescale 1ns/1ps
module tb_dmac_cfg;

    localparam int N = 4;
`ifdef DMAC_CFG_SLVERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             psel = 1'b0;
    logic             penable = 1'b0;
    logic [11:0]      paddr = '0;
    logic             pwrite = 1'b0;
    logic [31:0]      pwdata = '0;
    logic             pready;
    logic [31:0]      prdata;
    logic             pslverr;
    logic [N-1:0][31:0] src;
    logic [N-1:0][31:0] dst;
    logic [N-1:0][15:0] len;
    logic [N-1:0]     start;
    logic [N-1:0]     done = '0;

    int n_err = 0;
    int n_chk = 0;
    int start_cnt = 0;
    bit chk_en = 0;
    bit rnd_done = 0;
    logic [N-1:0] done_req = '0;

    logic [31:0] m_src [N];
    logic [31:0] m_dst [N];
    logic [15:0] m_len [N];
    logic        m_busy [N];
    logic [N-1:0] m_start;
    logic [31:0] m_prdata;

    dmac_cfg #(.N_CH(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .psel_i     (psel),
        .penable_i  (penable),
        .paddr_i    (paddr),
        .pwrite_i   (pwrite),
        .pwdata_i   (pwdata),
        .pready_o   (pready),
        .prdata_o   (prdata),
        .pslverr_o  (pslverr),
        .ch_src_o   (src),
        .ch_dst_o   (dst),
        .ch_len_o   (len),
        .ch_start_o (start),
        .ch_done_i  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rval(input logic [11:0] a);
        int pg;
        int o;
        logic [31:0] v;
        pg = int'(a[11:8]);
        o  = int'(a[7:0]);
        v  = 32'h0;
        if (pg == 0 && o == 0) begin
            v = 32'h0002_0101;
        end else if (pg >= 1 && pg <= N) begin
            case (o)
                'h00: v = m_src[pg-1];
                'h04: v = m_dst[pg-1];
                'h08: v = {16'h0, m_len[pg-1]};
                'h10: v = {31'h0, ~m_busy[pg-1]};
                default: v = 32'h0;
            endcase
        end
        return v;
    endfunction

    function automatic logic exp_err();
        int pg;
        int o;
        logic e;
        pg = int'(paddr[11:8]);
        o  = int'(paddr[7:0]);
        e  = 1'b0;
        if (pg == 0) e = (o != 0) || pwrite;
        else if (pg > N) e = 1'b1;
        else e = !(o inside {0, 4, 8, 12, 16})
               || (pwrite && o == 16)
               || (pwrite && o == 12 && m_busy[pg-1]);
        return EXP_ERR && psel && penable && rst_n && e;
    endfunction

    // Reference model: spec-level register map updated per clock edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < N; c++) begin
                m_src[c] = '0;
                m_dst[c] = '0;
                m_len[c] = '0;
                m_busy[c] = 1'b0;
            end
            m_start = '0;
            m_prdata = '0;
        end else begin
            int pg;
            int o;
            logic wr;
            logic [N-1:0] st;
            pg = int'(paddr[11:8]);
            o  = int'(paddr[7:0]);
            wr = psel && penable && pwrite;
            st = '0;
            if (psel && !penable && !pwrite) m_prdata = rval(paddr);
            for (int c = 0; c < N; c++) begin
                if (wr && pg == c + 1) begin
                    if (o == 0) m_src[c] = pwdata;
                    if (o == 4) m_dst[c] = pwdata;
                    if (o == 8) m_len[c] = pwdata[15:0];
                end
                if (m_busy[c]) begin
                    if (done[c]) m_busy[c] = 1'b0;
                end else if (wr && pg == c + 1 && o == 12 && pwdata[0]) begin
                    m_busy[c] = 1'b1;
                    st[c] = 1'b1;
                end
            end
            m_start = st;
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            start_cnt += $countones(start);
            chk("start", 32'(start), 32'(m_start));
            for (int c = 0; c < N; c++) begin
                chk($sformatf("src%0d", c), src[c], m_src[c]);
                chk($sformatf("dst%0d", c), dst[c], m_dst[c]);
                chk($sformatf("len%0d", c), 32'(len[c]), 32'(m_len[c]));
            end
            chk("prdata", prdata, m_prdata);
            chk("pready", 32'(pready), 32'(psel & penable));
            chk("pslverr", 32'(pslverr), 32'(exp_err()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_done)
            done = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : '0;
        else
            done = done_req;
        done_req = '0;
    endtask

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d,
                             input logic [N-1:0] dn, output logic err);
        psel = 1'b1;
        penable = 1'b0;
        pwrite = 1'b1;
        paddr = a;
        pwdata = d;
        done_req = dn;
        step();
        penable = 1'b1;
        err = pslverr;
        step();
        psel = 1'b0;
        penable = 1'b0;
        pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d,
                            output logic err);
        psel = 1'b1;
        penable = 1'b0;
        pwrite = 1'b0;
        paddr = a;
        step();
        penable = 1'b1;
        d = prdata;
        err = pslverr;
        step();
        psel = 1'b0;
        penable = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          cnt0;

    initial begin
        #2 rst_n = 1'b0;
        chk_en = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        apb_read(12'h000, rd, er);
        chk("ipver", rd, 32'h0002_0101);
        apb_read(12'h110, rd, er);
        chk("stat0_rst", rd, 32'h1);
        apb_read(12'h100, rd, er);
        chk("src0_rst", rd, 32'h0);

        apb_write(12'h200, 32'h0000_1000, '0, er);
        apb_read(12'h200, rd, er);
        chk("src1", rd, 32'h0000_1000);
        apb_write(12'h208, 32'h0001_0100, '0, er);
        apb_read(12'h208, rd, er);
        chk("len1_rd", rd, 32'h0000_0100);
        chk("len1_port", 32'(len[1]), 32'h0100);

        apb_write(12'h30C, 32'h1, '0, er);
        chk("start2_on", 32'(start), 32'h4);
        step();
        chk("start2_off", 32'(start), 32'h0);
        apb_read(12'h310, rd, er);
        chk("stat2_busy", rd, 32'h0);
        apb_write(12'h30C, 32'h1, '0, er);
        chk("cmd_busy_err", 32'(er), 32'(EXP_ERR));
        chk("cmd_busy_nostart", 32'(start), 32'h0);
        done_req = 4'b0100;
        step();
        step();
        apb_read(12'h310, rd, er);
        chk("stat2_done", rd, 32'h1);

        apb_write(12'h10C, 32'h1, '0, er);
        apb_write(12'h10C, 32'h1, 4'b0001, er);
        chk("done_cmd_nostart", 32'(start), 32'h0);
        apb_read(12'h110, rd, er);
        chk("done_cmd_stat", rd, 32'h1);

        apb_write(12'h500, 32'hFFFF_FFFF, '0, er);
        chk("oob_wr_err", 32'(er), 32'(EXP_ERR));
        apb_read(12'h500, rd, er);
        chk("oob_rd", rd, 32'h0);
        chk("oob_rd_err", 32'(er), 32'(EXP_ERR));

        cnt0 = start_cnt;
        for (int c = 0; c < N; c++) begin
            apb_write(12'((c + 1) * 256 + 12), 32'h1, '0, er);
        end
        step();
        chk("all_started", 32'(start_cnt - cnt0), 32'd4);
        apb_read(12'h000, rd, er);
        rst_n = 1'b0;
        #1;
        chk("rst_prdata", prdata, 32'h0);
        chk("rst_src1", src[1], 32'h0);
        chk("rst_start", 32'(start), 32'h0);
        cnt0 = start_cnt;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        for (int c = 0; c < N; c++) begin
            apb_read(12'((c + 1) * 256 + 16), rd, er);
            chk($sformatf("rst_stat%0d", c), rd, 32'h1);
        end
        chk("rst_nopulse", 32'(start_cnt - cnt0), 32'd0);

        rnd_done = 1;
        for (int i = 0; i < 400; i++) begin
            logic [11:0] a;
            logic [31:0] d;
            int sel;
            sel = $urandom_range(0, 7);
            a[11:8] = 4'($urandom_range(0, 5));
            case (sel)
                0: a[7:0] = 8'h00;
                1: a[7:0] = 8'h04;
                2: a[7:0] = 8'h08;
                3, 4: a[7:0] = 8'h0C;
                5: a[7:0] = 8'h10;
                6: a[7:0] = 8'h14;
                default: a[7:0] = 8'($urandom_range(0, 255));
            endcase
            d = $urandom;
            if ($urandom_range(0, 1) == 1)
                apb_write(a, d, '0, er);
            else
                apb_read(a, rd, er);
        end
        rnd_done = 0;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
